fft_r22sdf_bitrev: RTL
======================

// Module: fft_r22sdf_bitrev
// PURPOSE
//  Reorders the R2^2 SDF FFT output from bit-reversed bin order into natural order.
//  Sits directly downstream of fft_r22sdf and consumes its sync/bin/re/im stream.
//  Uses a ping-pong buffer of two N-entry banks: one bank fills while the other drains.
//  Sustains one sample per clock continuously, with no back-pressure. The FFT cannot stall.
// PARAMETERS
//  N       1024  FFT length, power of 4
//  N_LOG2  10    log2(N)
//  DW      25    sample width per component; equals FFT OUTPUT_WIDTH
// PORTS
//  clk_i     in   1       single clock; all logic is posedge
//  rst_n     in   1       asynchronous, active-low reset
//  sync_i    in   1       FFT sync_o; high means re_i/im_i/ctr_i are valid this cycle
//  ctr_i     in   N_LOG2  FFT data_ctr_o: bit-reversed bin index of the current sample
//  re_i      in   DW      signed real part
//  im_i      in   DW      signed imaginary part
//  valid_o   out  1       re_o/im_o/bin_o are valid
//  sof_o     out  1       high with bin 0 of each output frame
//  bin_o     out  N_LOG2  natural-order bin index
//  re_o      out  DW      signed real part, natural order
//  im_o      out  DW      signed imaginary part, natural order
//  err_o     out  1       sticky: ctr_i disagreed with the expected bit-reversed count
// BEHAVIOUR
//  Reset (asynchronous assert, synchronous release):
//   - valid_o, sof_o, err_o = 0; bin_o, re_o, im_o = 0.
//   - wr_cnt, rd_cnt, wr_bank and rd_active are cleared.
//   - RAM contents are not cleared.
//  Write side:
//   - On each edge with sync_i=1, write {re_i,im_i} to RAM[wr_bank][ctr_i], then wr_cnt++.
//   - wr_cnt is a natural-order count, 0..N-1.
//   - When sync_i=1, wr_cnt==N-1 closes the frame: wr_cnt wraps to 0, wr_bank toggles,
//     and a read of the just-filled bank starts (rd_cnt=0, rd_active=1).
//   - If sync_i=0 mid-frame (FFT reset): wr_cnt goes to 0, the partial frame is discarded,
//     and wr_bank is unchanged. A read already in progress runs to completion.
//   - err_o sets when sync_i=1 and ctr_i != bitrev(wr_cnt). It clears only on rst_n.
//  Read side:
//   - While rd_active=1: read address = {~wr_bank, rd_cnt}, synchronous RAM read.
//   - rd_cnt++ each cycle. At rd_cnt==N-1, rd_active goes to 0 unless a new frame
//     closes on the same edge.
//   - Output registers follow the RAM by 1 cycle:
//     valid_o = rd_active delayed 2 cycles; bin_o = rd_cnt delayed 2 cycles;
//     sof_o = valid_o && bin_o==0.
//   - Simultaneous frame close and last read (back-to-back frames): rd_cnt wraps to 0 and
//     rd_active stays 1. valid_o stays high with no bubble.
//   - Rates are equal, so write never overtakes read. No full/empty flags exist.
//  Latency and ordering:
//   - Input sample k of a frame is captured at edge t0+k.
//   - Output bin j appears after edge t0+N+1+j, i.e. N+1 cycles from first input to bin 0.
//   - re_o/im_o are bit-exact copies of the input. No scaling or rounding.
//  Reset during a read: output stops immediately (valid_o=0). The first frame after reset
//   starts writing to bank 0.
// STRUCTURE
//  - fft_r22sdf_defines.vh: add a bitrev(N_LOG2) function macro and the DW/N_LOG2 defaults
//    shared with fft_r22sdf.
//  - Sub-module fft_r22sdf_bitrev_ram: simple dual-port RAM, 1 write / 1 sync read,
//    depth 2N, width 2*DW. Infers BRAM with no output register.
//  - Top level holds wr_cnt, wr_bank, rd_cnt, rd_active, the 2-stage valid/bin pipeline and
//    the err checker. Target 150-250 lines.
// TESTING  (bench: N=16, N_LOG2=4, DW=25)
//  1. Ramp: one frame with ctr_i = bitrev(0..15), re_i = ctr_i, im_i = -ctr_i.
//     Expect 17 cycles after the first input: bin_o = 0..15, re_o = 0..15, im_o = 0..-15,
//     sof_o only at bin 0, err_o = 0.
//  2. Back-to-back: 4 continuous frames, frame f data = 100*f + bin.
//     Expect valid_o high for 64 consecutive cycles with no gap, and output frame f = 100*f + 0..15.
//  3. Abort: drop sync_i after 7 samples of frame 1, then resume with a full frame 2.
//     Expect frame 0 output intact, frame 1 never output, frame 2 output correct.
//  4. Bad index: on sample 5 (expected ctr 10), drive ctr_i=3.
//     Expect err_o=1 from the next cycle until rst_n, with the data stream otherwise unaffected.
//  5. Reset mid-read: assert rst_n=0 at output bin 8.
//     Expect valid_o/re_o/im_o = 0 asynchronously. After release, a fresh frame has
//     latency N+1 = 17.
//  6. Extremes: re_i/im_i = +2^24-1 and -2^24 alternating.
//     Expect the values reproduced bit-exact in natural order.

Source files
------------

// File: rtl/fft_r22sdf_bitrev_pkg.sv
// rtl/fft_r22sdf_bitrev_pkg.sv - shared FFT reorder defaults and bit-reverse helper
// Purpose: default sizes shared with fft_r22sdf and a bit-reverse function used
//          to check the incoming bin index.
// Ports:   none (package).
package fft_r22sdf_bitrev_pkg;

  localparam int FFT_N      = 1024;
  localparam int FFT_N_LOG2 = 10;
  localparam int FFT_DW     = 25;

  // Reverses the low nbits of v; bits above nbits come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int nbits);
    logic [31:0] src;
    logic [31:0] r;
    src = v;
    r   = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < nbits) begin
        r   = {r[30:0], src[0]};
        src = src >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_r22sdf_bitrev_if.sv
// rtl/fft_r22sdf_bitrev_if.sv - FFT-side input stream and natural-order output stream
// Purpose: groups the bit-reversed input stream and the reordered output stream.
// Ports:   sync_i/ctr_i/re_i/im_i  input sample stream from fft_r22sdf
//          valid_o/sof_o/bin_o/re_o/im_o  natural-order output stream
//          err_o  sticky bin-index mismatch flag
// Modports: slave = reorder block, master = upstream FFT / downstream sink.
interface fft_r22sdf_bitrev_if
  import fft_r22sdf_bitrev_pkg::*;
#(
  parameter int N_LOG2 = FFT_N_LOG2,
  parameter int DW     = FFT_DW
);

  logic                     sync_i;
  logic [N_LOG2-1:0]        ctr_i;
  logic signed [DW-1:0]     re_i;
  logic signed [DW-1:0]     im_i;
  logic                     valid_o;
  logic                     sof_o;
  logic [N_LOG2-1:0]        bin_o;
  logic signed [DW-1:0]     re_o;
  logic signed [DW-1:0]     im_o;
  logic                     err_o;

  modport slave (
    input  sync_i, ctr_i, re_i, im_i,
    output valid_o, sof_o, bin_o, re_o, im_o, err_o
  );

  modport master (
    output sync_i, ctr_i, re_i, im_i,
    input  valid_o, sof_o, bin_o, re_o, im_o, err_o
  );

endinterface

// File: rtl/fft_r22sdf_bitrev_ram.sv
// rtl/fft_r22sdf_bitrev_ram.sv - simple dual-port RAM, one write and one synchronous read
// Purpose: ping-pong sample store; bank select is the address MSB.
// Ports:   clk_i    clock
//          we_i, waddr_i, wdata_i  write port
//          re_i, raddr_i, rdata_o  synchronous read port (no output register)
module fft_r22sdf_bitrev_ram
  import fft_r22sdf_bitrev_pkg::*;
#(
  parameter int AW = FFT_N_LOG2 + 1,
  parameter int DW = 2 * FFT_DW
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem[raddr_i];
    end
  end

endmodule

// File: rtl/fft_r22sdf_bitrev.sv
// rtl/fft_r22sdf_bitrev.sv - bit-reversed to natural-order reorder buffer for fft_r22sdf
// Purpose: writes each FFT sample at its bit-reversed bin address into the filling
//          bank and streams the other bank out in natural order, one sample per clock.
// Ports:   clk_i  clock
//          rst_n  asynchronous active-low reset
//          bus    fft_r22sdf_bitrev_if.slave (input stream, output stream, err_o)
module fft_r22sdf_bitrev
  import fft_r22sdf_bitrev_pkg::*;
#(
  parameter int N      = FFT_N,
  parameter int N_LOG2 = FFT_N_LOG2,
  parameter int DW     = FFT_DW
) (
  input  logic               clk_i,
  input  logic               rst_n,
  fft_r22sdf_bitrev_if.slave bus
);

  localparam logic [N_LOG2-1:0] LAST = N_LOG2'(N - 1);

  logic [N_LOG2-1:0] wr_cnt;
  logic [N_LOG2-1:0] rd_cnt;
  logic [N_LOG2-1:0] bin_d1;
  logic              wr_bank;
  logic              rd_active;
  logic              valid_d1;
  logic              frame_close;
  logic [31:0]       exp_ctr;
  logic [2*DW-1:0]   rd_data;

  assign frame_close = bus.sync_i && (wr_cnt == LAST);
  assign exp_ctr     = bitrev({{(32-N_LOG2){1'b0}}, wr_cnt}, N_LOG2);

  // The draining bank is always the one not being written.
  fft_r22sdf_bitrev_ram #(
    .AW (N_LOG2 + 1),
    .DW (2 * DW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (bus.sync_i),
    .waddr_i ({wr_bank, bus.ctr_i}),
    .wdata_i ({bus.re_i, bus.im_i}),
    .re_i    (rd_active),
    .raddr_i ({~wr_bank, rd_cnt}),
    .rdata_o (rd_data)
  );

  // Write side: a sync_i drop discards the partial frame but keeps the bank.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt    <= '0;
      wr_bank   <= 1'b0;
      bus.err_o <= 1'b0;
    end else if (bus.sync_i) begin
      wr_cnt <= wr_cnt + 1'b1;
      if (wr_cnt == LAST) begin
        wr_bank <= ~wr_bank;
      end
      if ({{(32-N_LOG2){1'b0}}, bus.ctr_i} != exp_ctr) begin
        bus.err_o <= 1'b1;
      end
    end else begin
      wr_cnt <= '0;
    end
  end

  // Read side: a frame close restarts the read even on its last cycle,
  // which keeps back-to-back frames gapless.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt    <= '0;
      rd_active <= 1'b0;
    end else if (frame_close) begin
      rd_cnt    <= '0;
      rd_active <= 1'b1;
    end else if (rd_active) begin
      rd_cnt <= rd_cnt + 1'b1;
      if (rd_cnt == LAST) begin
        rd_active <= 1'b0;
      end
    end
  end

  // Stage 1 lines up with the RAM read, stage 2 is the output register.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      valid_d1    <= 1'b0;
      bin_d1      <= '0;
      bus.valid_o <= 1'b0;
      bus.sof_o   <= 1'b0;
      bus.bin_o   <= '0;
      bus.re_o    <= '0;
      bus.im_o    <= '0;
    end else begin
      valid_d1    <= rd_active;
      bin_d1      <= rd_cnt;
      bus.valid_o <= valid_d1;
      bus.bin_o   <= bin_d1;
      bus.sof_o   <= valid_d1 && (bin_d1 == '0);
      if (valid_d1) begin
        bus.re_o <= rd_data[2*DW-1:DW];
        bus.im_o <= rd_data[DW-1:0];
      end
    end
  end

endmodule
